frame_sram_reader: RTL and testbench
====================================

# frame_sram_reader

Read-back engine for the downscaled frame held in the single-port image SRAM. On a start pulse it becomes the SRAM bus master. It walks a rectangular region of `cfg_width × cfg_height` bytes starting at `cfg_base` in raster order, using the SRAM's 1-cycle registered read. It emits the bytes as a valid/ready pixel stream with row-end and frame-end markers. It is the reader counterpart of the control unit's result writer and shares the SRAM through the top-level busy-based arbitration mux.

## Interface
- `ADDR_BITS`, 16, SRAM address width; addresses wrap modulo 2^ADDR_BITS.
- `DIM_BITS`, 16, width of `cfg_width` and `cfg_height`.
- `clk`  in  1  single clock for all logic.
- `aclr_n`  in  1  reset, asynchronous, active-low; clears all state.
- `start`  in  1  1-cycle start pulse; sampled only in IDLE or DONE.
- `cfg_base`  in  ADDR_BITS  address of pixel (0,0); sampled on accepted start.
- `cfg_width`  in  DIM_BITS  pixels per row; sampled on accepted start.
- `cfg_height`  in  DIM_BITS  rows; sampled on accepted start.
- `busy`  out  1  high while the block owns the SRAM; drives the arbitration mux select.
- `done`  out  1  level; high from frame completion until the next accepted start.
- `mem_we`  out  1  constant 0.
- `mem_addr`  out  ADDR_BITS  read address.
- `mem_data_in`  in  8  SRAM read data; valid the cycle after `mem_addr` is presented.
- `pix_valid`  out  1  stream valid.
- `pix_ready`  in  1  stream ready.
- `pix_data`  out  8  pixel byte.
- `pix_eol`  out  1  with `pix_data`; last column of a row.
- `pix_eof`  out  1  with `pix_data`; last pixel of the frame (implies `pix_eol`).

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE → RUN: on `start`, latch the config, clear row/col counters, set address pointer = `cfg_base`, clear `done`.
- IDLE/DONE → DONE (directly): on `start` with `cfg_width == 0` or `cfg_height == 0`. No reads issued; `busy` never asserts.
- RUN issue rule: issue a read when `occ + inflight − pop < 2`.
  - `occ` is the output FIFO count (0..2).
  - `inflight` is 1 if a read was issued last cycle, else 0.
  - `pop = pix_valid & pix_ready`.
- Each issue presents `mem_addr = ptr`, then advances `ptr` (+1, wrapping) and col/row.
  - col wraps at `width−1`; row increments on col wrap.
- Returned data is pushed into the FIFO tagged with eol (col was `width−1`) and eof (also row was `height−1`).
- RUN → DRAIN: once the last address has been issued.
- DRAIN → DONE: when the eof-tagged pixel is popped.
- DONE holds `done = 1` and waits for `start`.
- `start` in RUN/DRAIN is ignored.
- The FIFO never overflows given the issue rule. Assert this in simulation.
- Reset mid-frame: state → IDLE, FIFO emptied, all outputs to reset values. In-flight SRAM data is discarded.
- Reset values: `busy = 0`, `done = 0`, `mem_we = 0`, `mem_addr = 0`, `pix_valid = 0`, `pix_data = 0`, `pix_eol = 0`, `pix_eof = 0`.

## Timing
- `start` sampled at edge E0. After E0: `busy = 1` and `mem_addr = cfg_base`.
- SRAM data appears after E1. FIFO captures at E2. `pix_valid` is first high after E2, giving 2-cycle start-to-first-pixel latency.
- With `pix_ready` held high: one pixel per cycle, a W×H frame completes in W·H+2 cycles after E0.
- `pix_valid`/`pix_data`/`pix_eol`/`pix_eof` are driven from FIFO registers. They hold stable while `pix_valid & !pix_ready`.
- Once `pix_valid` is high it stays high until popped.
- `pix_ready` may combinationally affect read issue in the same cycle. No output depends combinationally on `pix_ready`.
- Last pixel popped at edge En: after En, `busy = 0`, `done = 1`, `pix_valid = 0`.

## Structure
- Package `frame_rd_pkg`:
  - state enum `frd_state_t` {IDLE, RUN, DRAIN, DONE}
  - `FRD_FIFO_DEPTH = 2`
  - FIFO entry struct {data[7:0], eol, eof}
- Sub-module `pix_fifo2`: 2-entry register FIFO with push/pop and count output. Simultaneous push and pop are allowed at any count, including push+pop at count 2 only if a pop occurs.

## Test plan
- Frame W=3, H=2, base 0x0100, SRAM[0x0100..0x0105] = 10..15, ready high:
  - stream 10..15 on six consecutive cycles starting 2 cycles after start
  - `pix_eol` on 12 and 15, `pix_eof` on 15
  - `busy` low and `done` high the cycle after the 15 is popped.
- Same frame, `pix_ready` toggling 1,0,0,1,…:
  - identical byte order with no drops or duplicates
  - outputs stable during stalls
  - `mem_addr` never runs more than 2 ahead of popped pixels.
- W=0, H=5, start:
  - `done` = 1 the next cycle
  - `busy` never high, `pix_valid` never high, no `mem_addr` change.
- W=4, H=1, base 0xFFFE:
  - addresses issued are 0xFFFE, 0xFFFF, 0x0000, 0x0001
  - eof on the fourth pixel.
- Start pulse while busy, with different cfg values: ignored; the original frame completes unchanged.
- `aclr_n` low for 1 cycle after 3 of 6 pixels:
  - all outputs at reset values, no further pixels
  - a new start then reproduces the full 6-pixel frame.

Source files
------------

// File: rtl/frame_sram_reader_pkg.sv
// Shared types for the frame SRAM read-back engine.
// State encoding, FIFO sizing and the buffered pixel entry.
package frame_rd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } frd_state_t;

  localparam int FRD_FIFO_DEPTH = 2;
  localparam int FRD_CNT_BITS =
    $clog2(FRD_FIFO_DEPTH + 1);

  typedef struct packed {
    logic [7:0] data;
    logic       eol;
    logic       eof;
  } frd_entry_t;

endpackage

// File: rtl/frame_sram_reader_if.sv
// SRAM read port plus outgoing pixel stream.
// master = reader engine, slave = SRAM/sink side.
interface frame_sram_reader_if #(
  parameter int ADDR_BITS = 16
);
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [7:0]           mem_data_in;
  logic                 pix_valid;
  logic                 pix_ready;
  logic [7:0]           pix_data;
  logic                 pix_eol;
  logic                 pix_eof;

  modport master (
    output mem_we,
    output mem_addr,
    input  mem_data_in,
    output pix_valid,
    input  pix_ready,
    output pix_data,
    output pix_eol,
    output pix_eof
  );

  modport slave (
    input  mem_we,
    input  mem_addr,
    output mem_data_in,
    input  pix_valid,
    output pix_ready,
    input  pix_data,
    input  pix_eol,
    input  pix_eof
  );
endinterface

// File: rtl/frame_sram_reader_fifo.sv
// Two-entry register FIFO; the head register is slot s0,
// so stream outputs come straight from flops.
module pix_fifo2
  import frame_rd_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  frd_entry_t              din,
  input  logic                    pop,
  output frd_entry_t              head,
  output logic [FRD_CNT_BITS-1:0] count
);

  frd_entry_t s0;
  frd_entry_t s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0    <= '0;
      s1    <= '0;
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == '0) s0 <= din;
          else             s1 <= din;
          count <= count + 1'b1;
        end
        2'b01: begin
          s0    <= s1;
          count <= count - 1'b1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            s0 <= din;
          end else begin
            s0 <= s1;
            s1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = s0;

  localparam logic [FRD_CNT_BITS-1:0] FULL =
    FRD_CNT_BITS'(FRD_FIFO_DEPTH);

  a_no_ovf: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(push && !pop && count == FULL));

  a_no_unf: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(pop && count == '0));

endmodule

// File: rtl/frame_sram_reader.sv
// Raster read-back of a W x H byte region from the
// image SRAM into a valid/ready pixel stream.
module frame_sram_reader
  import frame_rd_pkg::*;
#(
  parameter int ADDR_BITS = 16,
  parameter int DIM_BITS  = 16
) (
  input  logic                 clk,
  input  logic                 aclr_n,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] cfg_base,
  input  logic [DIM_BITS-1:0]  cfg_width,
  input  logic [DIM_BITS-1:0]  cfg_height,
  output logic                 busy,
  output logic                 done,
  frame_sram_reader_if.master  bus
);

  frd_state_t           state;
  logic [ADDR_BITS-1:0] ptr;
  logic [DIM_BITS-1:0]  w;
  logic [DIM_BITS-1:0]  h;
  logic [DIM_BITS-1:0]  col;
  logic [DIM_BITS-1:0]  row;
  logic                 inflight;
  logic                 fl_eol;
  logic                 fl_eof;

  frd_entry_t              head;
  frd_entry_t              din;
  logic [FRD_CNT_BITS-1:0] occ;
  logic [2:0]              load;
  logic                    pop;
  logic                    issue;
  logic                    col_last;
  logic                    row_last;
  logic                    go;
  logic                    zero_dim;

  assign bus.mem_we    = 1'b0;
  assign bus.mem_addr  = ptr;
  assign bus.pix_valid = (occ != '0);
  assign bus.pix_data  = head.data;
  assign bus.pix_eol   = head.eol;
  assign bus.pix_eof   = head.eof;

  assign pop      = bus.pix_valid & bus.pix_ready;
  assign col_last = (col == w - 1'b1);
  assign row_last = (row == h - 1'b1);
  assign go       = start &&
                    (state == IDLE || state == DONE);
  assign zero_dim = (cfg_width == '0) ||
                    (cfg_height == '0);

  // buffered + returning - leaving must leave room
  assign load  = 3'(occ) + 3'(inflight) - 3'(pop);
  assign issue = (state == RUN) && (load < 3'd2);

  assign din = '{data: bus.mem_data_in,
                 eol:  fl_eol,
                 eof:  fl_eof};

  pix_fifo2 u_fifo (
    .clk   (clk),
    .rst_n (aclr_n),
    .push  (inflight),
    .din   (din),
    .pop   (pop),
    .head  (head),
    .count (occ)
  );

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      ptr      <= '0;
      w        <= '0;
      h        <= '0;
      col      <= '0;
      row      <= '0;
      inflight <= 1'b0;
      fl_eol   <= 1'b0;
      fl_eof   <= 1'b0;
    end else begin
      inflight <= issue;
      fl_eol   <= col_last;
      fl_eof   <= col_last && row_last;
      if (issue) begin
        ptr <= ptr + 1'b1;
        if (col_last) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      unique case (state)
        IDLE, DONE: begin
          if (go && zero_dim) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (go) begin
            state <= RUN;
            busy  <= 1'b1;
            done  <= 1'b0;
            w     <= cfg_width;
            h     <= cfg_height;
            col   <= '0;
            row   <= '0;
            ptr   <= cfg_base;
          end
        end
        RUN: begin
          if (issue && col_last && row_last)
            state <= DRAIN;
        end
        DRAIN: begin
          if (pop && head.eof) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_sram_reader.sv
// Directed bench for frame_sram_reader with a
// registered-read SRAM model and a pixel sink.
module tb_frame_sram_reader;
  import frame_rd_pkg::*;

  logic        clk;
  logic        aclr_n;
  logic        start;
  logic [15:0] cfg_base;
  logic [15:0] cfg_width;
  logic [15:0] cfg_height;
  logic        busy;
  logic        done;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] sram [0:65535];

  frame_sram_reader_if #(.ADDR_BITS(16)) bus ();

  frame_sram_reader #(
    .ADDR_BITS (16),
    .DIM_BITS  (16)
  ) dut (
    .clk        (clk),
    .aclr_n     (aclr_n),
    .start      (start),
    .cfg_base   (cfg_base),
    .cfg_width  (cfg_width),
    .cfg_height (cfg_height),
    .busy       (busy),
    .done       (done),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    bus.mem_data_in <= sram[bus.mem_addr];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pix();
    return {21'd0, bus.pix_valid, bus.pix_data,
            bus.pix_eol, bus.pix_eof};
  endfunction

  function automatic logic [31:0] mk(
    input logic v, input logic [7:0] d,
    input logic l, input logic f);
    return {21'd0, v, d, l, f};
  endfunction

  task automatic kick(input logic [15:0] b,
                      input logic [15:0] wd,
                      input logic [15:0] ht);
    @(negedge clk);
    start      = 1'b1;
    cfg_base   = b;
    cfg_width  = wd;
    cfg_height = ht;
  endtask

  // Full frame through the sink; expectations come
  // from the bench's own SRAM image and raster math.
  task automatic run_frame(input string tag,
                           input logic [15:0] b,
                           input int wd, input int ht,
                           input bit toggle,
                           input bit poke);
    int n = wd * ht;
    int idx = 0;
    int cyc = 0;
    int k = 0;
    int ahead;
    int max_ahead = 0;
    bit fin = 0;
    bit stall = 0;
    logic [31:0] last = '0;
    logic [15:0] a;
    kick(b, 16'(wd), 16'(ht));
    bus.pix_ready = 1'b1;
    while (!fin && cyc < 100) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (poke && cyc == 2) begin
        start      = 1'b1;
        cfg_base   = 16'h0200;
        cfg_width  = 16'd2;
        cfg_height = 16'd2;
      end
      if (stall) chk({tag, "_stable"}, pix(), last);
      ahead = int'(16'(bus.mem_addr - b)) - idx;
      if (ahead > max_ahead) max_ahead = ahead;
      if (done) begin
        fin = 1;
        chk({tag, "_end"},
            {30'd0, busy, bus.pix_valid}, 32'd0);
      end else begin
        bus.pix_ready = toggle ?
          ((k % 4) == 0 || (k % 4) == 3) : 1'b1;
        k++;
        if (bus.pix_valid && bus.pix_ready) begin
          a = b + 16'(idx);
          chk({tag, "_px"}, pix(),
              mk(1'b1, sram[a],
                 (idx % wd) == wd - 1,
                 idx == n - 1));
          idx++;
        end
        stall = bus.pix_valid && !bus.pix_ready;
        last  = pix();
      end
    end
    start = 1'b0;
    chk({tag, "_done"}, 32'(fin), 32'd1);
    chk({tag, "_count"}, idx, n);
    chk({tag, "_ahead"}, 32'(max_ahead <= 2), 32'd1);
  endtask

  initial begin
    clk           = 1'b0;
    aclr_n        = 1'b0;
    start         = 1'b0;
    cfg_base      = '0;
    cfg_width     = '0;
    cfg_height    = '0;
    bus.pix_ready = 1'b0;
    for (int i = 0; i < 65536; i++)
      sram[i] = 8'(i * 7 + 3);
    for (int i = 0; i < 6; i++)
      sram[16'h0100 + i] = 8'(10 + i);
    sram[16'hFFFE] = 8'hA0;
    sram[16'hFFFF] = 8'hA1;
    sram[16'h0000] = 8'hA2;
    sram[16'h0001] = 8'hA3;

    // reset values
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_we", 32'(bus.mem_we), 32'd0);
    chk("rst_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_pix", pix(), 32'd0);
    @(negedge clk);
    aclr_n = 1'b1;

    // zero-width frame completes without reads
    kick(16'h1234, 16'd0, 16'd5);
    @(negedge clk);
    start = 1'b0;
    chk("zero_done", 32'(done), 32'd1);
    for (int t = 0; t < 3; t++) begin
      chk("zero_quiet",
          {15'd0, busy, bus.pix_valid,
           bus.mem_addr[14:0]}, 32'd0);
      @(negedge clk);
    end

    // 3x2 frame, exact latency with ready high
    bus.pix_ready = 1'b1;
    kick(16'h0100, 16'd3, 16'd2);
    for (int t = 1; t <= 9; t++) begin
      @(negedge clk);
      start = 1'b0;
      if (t == 1) begin
        chk("lat_busy", {busy, done}, 32'b10);
        chk("lat_a0", 32'(bus.mem_addr), 32'h100);
      end
      if (t == 2)
        chk("lat_a1", 32'(bus.mem_addr), 32'h101);
      if (t <= 2)
        chk("lat_idle", 32'(bus.pix_valid), 32'd0);
      if (t >= 3 && t <= 8)
        chk("lat_px", pix(),
            mk(1'b1, 8'(10 + t - 3),
               t == 5 || t == 8, t == 8));
      if (t == 8) chk("lat_busy8", {busy, done}, 32'b10);
      if (t == 9) begin
        chk("lat_fin", {busy, done}, 32'b01);
        chk("lat_fin_v", 32'(bus.pix_valid), 32'd0);
      end
    end

    // same frame under 1,0,0,1 backpressure
    run_frame("bp", 16'h0100, 3, 2, 1'b1, 1'b0);

    // address wrap at the top of the SRAM
    bus.pix_ready = 1'b1;
    kick(16'hFFFE, 16'd4, 16'd1);
    for (int t = 1; t <= 7; t++) begin
      logic [15:0] ea;
      @(negedge clk);
      start = 1'b0;
      ea = 16'hFFFE + 16'(t - 1);
      if (t <= 4) chk("wrap_addr", 32'(bus.mem_addr), 32'(ea));
      if (t >= 3 && t <= 6)
        chk("wrap_px", pix(),
            mk(1'b1, 8'hA0 + 8'(t - 3), t == 6, t == 6));
      if (t == 7) chk("wrap_fin", {busy, done}, 32'b01);
    end

    // start while busy is ignored
    run_frame("poke", 16'h0100, 3, 2, 1'b0, 1'b1);

    // reset after three of six pixels
    bus.pix_ready = 1'b1;
    kick(16'h0100, 16'd3, 16'd2);
    for (int t = 1; t <= 6; t++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("mid_px", pix(), mk(1'b1, 8'd13, 1'b0, 1'b0));
    aclr_n = 1'b0;
    #1;
    chk("mid_rst_ctl",
        {busy, done, bus.mem_we}, 32'd0);
    chk("mid_rst_addr", 32'(bus.mem_addr), 32'd0);
    chk("mid_rst_pix", pix(), 32'd0);
    @(negedge clk);
    aclr_n = 1'b1;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      chk("post_rst_quiet",
          {busy, done, bus.pix_valid}, 32'd0);
    end
    run_frame("rerun", 16'h0100, 3, 2, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
